// File: rtl/axi_bridge_pkg.sv
// Shared encodings and helpers for the cache-to-AXI3 bridge: request type codes,
// burst encodings, FSM state types and line-address extraction.
package axi_bridge_pkg;

    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_e;

    // Unknown type codes fall through to a full-word transfer.
    function automatic logic [2:0] type_size(input logic [2:0] t);
        case (t)
            TYPE_BYTE: return 3'd0;
            TYPE_HALF: return 3'd1;
            default:   return 3'd2;
        endcase
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] a, input int shift);
        return a >> shift;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the pointer port has top priority; after an accepted
// grant to port p the pointer moves to (p+1) mod N.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_q) + i) % N;
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
        if (gnt_vld) gnt[gnt_idx] = 1'b1;

        ptr_d = ptr_q;
        if (adv && gnt_vld) begin
            if (int'(gnt_idx) == N - 1) ptr_d = '0;
            else                        ptr_d = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_cache_bridge.sv
// Shares one AXI3 master between N_PORT cache ports: independent read and write
// engines, one outstanding transaction each, with a one-line write buffer.
module axi_cache_bridge
    import axi_bridge_pkg::*;
#(
    parameter int N_PORT     = 2,
    parameter int LINE_WORDS = 4,
    parameter int ID_W       = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [N_PORT-1:0]                rd_req,
    input  logic [3*N_PORT-1:0]              rd_type,
    input  logic [32*N_PORT-1:0]             rd_addr,
    output logic [N_PORT-1:0]                rd_rdy,
    output logic [N_PORT-1:0]                ret_valid,
    output logic [N_PORT-1:0]                ret_last,
    output logic [31:0]                      ret_data,
    input  logic [N_PORT-1:0]                wr_req,
    input  logic [3*N_PORT-1:0]              wr_type,
    input  logic [32*N_PORT-1:0]             wr_addr,
    input  logic [4*N_PORT-1:0]              wr_wstrb,
    input  logic [32*LINE_WORDS*N_PORT-1:0]  wr_data,
    output logic [N_PORT-1:0]                wr_rdy,
    output logic [ID_W-1:0]                  arid,
    output logic [31:0]                      araddr,
    output logic [3:0]                       arlen,
    output logic [2:0]                       arsize,
    output logic [1:0]                       arburst,
    output logic [1:0]                       arlock,
    output logic [3:0]                       arcache,
    output logic [2:0]                       arprot,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [ID_W-1:0]                  rid,
    input  logic [31:0]                      rdata,
    input  logic [1:0]                       rresp,
    input  logic                             rlast,
    input  logic                             rvalid,
    output logic                             rready,
    output logic [ID_W-1:0]                  awid,
    output logic [31:0]                      awaddr,
    output logic [3:0]                       awlen,
    output logic [2:0]                       awsize,
    output logic [1:0]                       awburst,
    output logic [1:0]                       awlock,
    output logic [3:0]                       awcache,
    output logic [2:0]                       awprot,
    output logic                             awvalid,
    input  logic                             awready,
    output logic [ID_W-1:0]                  wid,
    output logic [31:0]                      wdata,
    output logic [3:0]                       wstrb,
    output logic                             wlast,
    output logic                             wvalid,
    input  logic                             wready,
    input  logic [ID_W-1:0]                  bid,
    input  logic [1:0]                       bresp,
    input  logic                             bvalid,
    output logic                             bready,
    output logic                             axi_err
);

    localparam int         IDX_W      = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam int         LINE_W     = 32 * LINE_WORDS;
    localparam int         LINE_SHIFT = $clog2(4 * LINE_WORDS);
    localparam logic [3:0] LINE_LEN   = 4'(LINE_WORDS - 1);

    r_state_e           r_state_q, r_state_d;
    w_state_e           w_state_q, w_state_d;
    logic [IDX_W-1:0]   r_owner_q, r_owner_d, w_owner_q, w_owner_d;
    logic [31:0]        araddr_q, araddr_d, awaddr_q, awaddr_d;
    logic [3:0]         arlen_q, arlen_d, awlen_q, awlen_d;
    logic [2:0]         arsize_q, arsize_d, awsize_q, awsize_d;
    logic [3:0]         wstrb_q, wstrb_d, beat_q, beat_d;
    logic [N_PORT-1:0]  ret_valid_q, ret_valid_d, ret_last_q, ret_last_d;
    logic [31:0]        ret_data_q, ret_data_d;
    logic               axi_err_q, axi_err_d;
    logic [LINE_W-1:0]  wbuf_q, wbuf_d;

    logic [N_PORT-1:0]  rd_elig, rd_gnt, wr_gnt;
    logic [IDX_W-1:0]   rd_idx, wr_idx;
    logic               rd_vld, wr_vld, w_line_busy;
    logic [31:0]        w_line;
    logic [2:0]         rd_t, wr_t;

    // One write is outstanding at a time, so the B-channel ID carries no information.
    logic bid_unused;
    assign bid_unused = ^bid;

    rr_arbiter #(.N(N_PORT)) u_rd_arb (
        .clk(clk), .rst_n(resetn), .req(rd_elig), .adv(r_state_q == R_IDLE),
        .gnt(rd_gnt), .gnt_idx(rd_idx), .gnt_vld(rd_vld)
    );

    rr_arbiter #(.N(N_PORT)) u_wr_arb (
        .clk(clk), .rst_n(resetn), .req(wr_req), .adv(w_state_q == W_IDLE),
        .gnt(wr_gnt), .gnt_idx(wr_idx), .gnt_vld(wr_vld)
    );

    // A read may not overtake a buffered (or just-accepted) write to the same line.
    always_comb begin
        w_line_busy = (w_state_q != W_IDLE);
        w_line      = line_addr(awaddr_q, LINE_SHIFT);
        if (w_state_q == W_IDLE && wr_vld) begin
            w_line_busy = 1'b1;
            w_line      = line_addr(wr_addr[wr_idx*32 +: 32], LINE_SHIFT);
        end
        rd_elig = '0;
        for (int i = 0; i < N_PORT; i++)
            rd_elig[i] = rd_req[i] &&
                         !(w_line_busy && line_addr(rd_addr[i*32 +: 32], LINE_SHIFT) == w_line);
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_owner_d   = r_owner_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        ret_valid_d = '0;
        ret_last_d  = '0;
        ret_data_d  = ret_data_q;
        axi_err_d   = axi_err_q;
        rd_t        = rd_type[rd_idx*3 +: 3];
        case (r_state_q)
            R_IDLE: if (rd_vld) begin
                r_owner_d = rd_idx;
                araddr_d  = rd_addr[rd_idx*32 +: 32];
                arsize_d  = type_size(rd_t);
                arlen_d   = (rd_t == TYPE_LINE) ? LINE_LEN : 4'd0;
                r_state_d = R_AR;
            end
            R_AR: if (arready) r_state_d = R_DATA;
            R_DATA: if (rvalid) begin
                ret_valid_d[r_owner_q] = 1'b1;
                ret_last_d[r_owner_q]  = rlast;
                ret_data_d             = rdata;
                if (rresp != 2'b00 || rid != ID_W'(r_owner_q)) axi_err_d = 1'b1;
                if (rlast) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (w_state_q == W_B && bvalid && bresp != 2'b00) axi_err_d = 1'b1;
    end

    always_comb begin
        w_state_d = w_state_q;
        w_owner_d = w_owner_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        wstrb_d   = wstrb_q;
        beat_d    = beat_q;
        wbuf_d    = wbuf_q;
        wr_t      = wr_type[wr_idx*3 +: 3];
        case (w_state_q)
            W_IDLE: if (wr_vld) begin
                w_owner_d = wr_idx;
                awaddr_d  = wr_addr[wr_idx*32 +: 32];
                awsize_d  = type_size(wr_t);
                awlen_d   = (wr_t == TYPE_LINE) ? LINE_LEN : 4'd0;
                wstrb_d   = (wr_t == TYPE_LINE) ? 4'hF : wr_wstrb[wr_idx*4 +: 4];
                wbuf_d    = wr_data[wr_idx*LINE_W +: LINE_W];
                beat_d    = 4'd0;
                w_state_d = W_AW;
            end
            W_AW: if (awready) w_state_d = W_DATA;
            W_DATA: if (wready) begin
                if (wlast) w_state_d = W_B;
                else       beat_d    = beat_q + 4'd1;
            end
            W_B: if (bvalid) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q   <= R_IDLE;
            w_state_q   <= W_IDLE;
            r_owner_q   <= '0;
            w_owner_q   <= '0;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            arlen_q     <= '0;
            awlen_q     <= '0;
            arsize_q    <= '0;
            awsize_q    <= '0;
            wstrb_q     <= '0;
            beat_q      <= '0;
            ret_valid_q <= '0;
            ret_last_q  <= '0;
            ret_data_q  <= '0;
            axi_err_q   <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            w_state_q   <= w_state_d;
            r_owner_q   <= r_owner_d;
            w_owner_q   <= w_owner_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            arlen_q     <= arlen_d;
            awlen_q     <= awlen_d;
            arsize_q    <= arsize_d;
            awsize_q    <= awsize_d;
            wstrb_q     <= wstrb_d;
            beat_q      <= beat_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            ret_data_q  <= ret_data_d;
            axi_err_q   <= axi_err_d;
        end
    end

    // Line payload is qualified by the write FSM state and needs no reset.
    always_ff @(posedge clk) wbuf_q <= wbuf_d;

    assign rd_rdy    = rd_gnt & {N_PORT{resetn && r_state_q == R_IDLE}};
    assign wr_rdy    = wr_gnt & {N_PORT{resetn && w_state_q == W_IDLE}};
    assign ret_valid = ret_valid_q;
    assign ret_last  = ret_last_q;
    assign ret_data  = ret_data_q;
    assign axi_err   = axi_err_q;

    assign arid    = ID_W'(r_owner_q);
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (r_state_q == R_AR);
    assign rready  = (r_state_q == R_DATA);

    assign awid    = ID_W'(w_owner_q);
    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (w_state_q == W_AW);
    assign wid     = ID_W'(w_owner_q);
    assign wdata   = wbuf_q[beat_q*32 +: 32];
    assign wstrb   = wstrb_q;
    assign wlast   = (w_state_q == W_DATA) && (beat_q == awlen_q);
    assign wvalid  = (w_state_q == W_DATA);
    assign bready  = (w_state_q == W_B);

endmodule
